// File: rtl/reg_writeback_pkg.sv
// Shared types for the writeback stage: word/address typedefs and the halt FSM state.
package reg_writeback_pkg;

    localparam int WB_WORD_W = 16;
    localparam int WB_NREG   = 16;
    localparam int WB_ADDR_W = 4;
    localparam int WB_DEPTH  = 2;

    typedef logic [WB_WORD_W-1:0] block;
    typedef logic [WB_ADDR_W-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } wb_state_t;

endpackage

// File: rtl/wb_pending_fifo.sv
// In-order {addr, data} buffer for execute writes that lost the write port.
// Entry 0 is always the oldest; all entries are exposed for the read bypass.
module wb_pending_fifo #(
    parameter int DEPTH  = 2,
    parameter int WORD_W = 16,
    parameter int AW     = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push_i,
    input  logic [AW-1:0]                  push_addr_i,
    input  logic [WORD_W-1:0]              push_data_i,
    input  logic                           pop_i,
    output logic [CW-1:0]                  count_o,
    output logic [DEPTH-1:0][AW-1:0]       ent_addr_o,
    output logic [DEPTH-1:0][WORD_W-1:0]   ent_data_o,
    output logic [DEPTH-1:0]               ent_valid_o
);

    logic [DEPTH-1:0][AW-1:0]     addr_q, addr_d;
    logic [DEPTH-1:0][WORD_W-1:0] data_q, data_d;
    logic [CW-1:0]                count_q, count_d;

    // Pop shifts toward entry 0 first, so a same-cycle push lands right after the survivors.
    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        count_d = count_q;
        if (pop_i && (count_q != '0)) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                addr_d[i] = addr_q[i+1];
                data_d[i] = data_q[i+1];
            end
            count_d = count_q - CW'(1);
        end else begin
            count_d = count_q;
        end
        if (push_i && (count_d != CW'(DEPTH))) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == count_d) begin
                    addr_d[i] = push_addr_i;
                    data_d[i] = push_data_i;
                end else begin
                    addr_d[i] = addr_d[i];
                end
            end
            count_d = count_d + CW'(1);
        end else begin
            count_d = count_d;
        end
    end

    // Entry storage and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            addr_q  <= addr_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    // Per-entry valid derived from occupancy.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_valid_o[i] = (CW'(i) < count_q);
        end
    end

    assign count_o    = count_q;
    assign ent_addr_o = addr_q;
    assign ent_data_o = data_q;

endmodule

// File: rtl/reg_writeback.sv
// Writeback stage: register array with one write port shared by the mem and exe
// streams, a pending buffer for displaced exe writes, full read bypass, and halt drain.
module reg_writeback
    import reg_writeback_pkg::*;
#(
    parameter int WORD_W = WB_WORD_W,
    parameter int NREG   = WB_NREG,
    parameter int DEPTH  = WB_DEPTH,
    localparam int AW    = $clog2(NREG),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              do_mem_reg_write,
    input  logic [WORD_W-1:0] mem_value,
    input  logic [AW-1:0]     mem_reg_addr,
    input  logic              do_exe_reg_write,
    input  logic [WORD_W-1:0] exe_value,
    input  logic [AW-1:0]     exe_reg_addr,
    input  logic [AW-1:0]     rd_addr_a,
    input  logic [AW-1:0]     rd_addr_b,
    output logic [WORD_W-1:0] rd_data_a,
    output logic [WORD_W-1:0] rd_data_b,
    output logic              wb_stall,
    input  logic              do_halt,
    output logic              halted
);

    wb_state_t                    state_q, state_d;
    logic [WORD_W-1:0]            regs_q [NREG];
    logic [CW-1:0]                count_s;
    logic [DEPTH-1:0][AW-1:0]     ent_addr_s;
    logic [DEPTH-1:0][WORD_W-1:0] ent_data_s;
    logic [DEPTH-1:0]             ent_valid_s;

    logic              accept_s, mem_ok_s, exe_ok_s;
    logic              push_s, pop_s, we_s;
    logic [AW-1:0]     waddr_s;
    logic [WORD_W-1:0] wdata_s;

    wb_pending_fifo #(
        .DEPTH  (DEPTH),
        .WORD_W (WORD_W),
        .AW     (AW)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_s),
        .push_addr_i (exe_reg_addr),
        .push_data_i (exe_value),
        .pop_i       (pop_s),
        .count_o     (count_s),
        .ent_addr_o  (ent_addr_s),
        .ent_data_o  (ent_data_s),
        .ent_valid_o (ent_valid_s)
    );

    // Write-port arbitration: mem wins, then the buffer head, then a direct exe write.
    always_comb begin
        accept_s = (state_q != HALTED);
        wb_stall = (count_s == CW'(DEPTH)) && do_mem_reg_write && do_exe_reg_write;
        mem_ok_s = accept_s && do_mem_reg_write && (mem_reg_addr != '0);
        exe_ok_s = accept_s && do_exe_reg_write && (exe_reg_addr != '0) && !wb_stall;
        push_s   = 1'b0;
        pop_s    = 1'b0;
        we_s     = 1'b0;
        waddr_s  = '0;
        wdata_s  = '0;
        if (accept_s && do_mem_reg_write) begin
            we_s    = mem_ok_s;
            waddr_s = mem_reg_addr;
            wdata_s = mem_value;
            push_s  = exe_ok_s;
        end else if (accept_s && (count_s != '0)) begin
            pop_s   = 1'b1;
            we_s    = 1'b1;
            waddr_s = ent_addr_s[0];
            wdata_s = ent_data_s[0];
            push_s  = exe_ok_s;
        end else if (exe_ok_s) begin
            we_s    = 1'b1;
            waddr_s = exe_reg_addr;
            wdata_s = exe_value;
        end else begin
            we_s    = 1'b0;
        end
    end

    // Register array; address 0 is never written because writers filter it out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_s) begin
            regs_q[waddr_s] <= wdata_s;
        end else begin
            regs_q[0] <= '0;
        end
    end

    // Later assignments take priority: array, buffer oldest-to-newest, mem, exe, then r0.
    function automatic logic [WORD_W-1:0] bypass_read(
        input logic [AW-1:0]                ra,
        input logic [WORD_W-1:0]            arr_val,
        input logic [DEPTH-1:0][AW-1:0]     e_addr,
        input logic [DEPTH-1:0][WORD_W-1:0] e_data,
        input logic [DEPTH-1:0]             e_valid,
        input logic                         m_ok,
        input logic [AW-1:0]                m_addr,
        input logic [WORD_W-1:0]            m_val,
        input logic                         x_ok,
        input logic [AW-1:0]                x_addr,
        input logic [WORD_W-1:0]            x_val
    );
        logic [WORD_W-1:0] res;
        res = arr_val;
        for (int i = 0; i < DEPTH; i++) begin
            if (e_valid[i] && (e_addr[i] == ra)) res = e_data[i];
        end
        if (m_ok && (m_addr == ra)) res = m_val;
        if (x_ok && (x_addr == ra)) res = x_val;
        if (ra == '0) res = '0;
        return res;
    endfunction

    // Combinational read ports.
    always_comb begin
        rd_data_a = bypass_read(rd_addr_a, regs_q[rd_addr_a], ent_addr_s, ent_data_s,
                                ent_valid_s, mem_ok_s, mem_reg_addr, mem_value,
                                exe_ok_s, exe_reg_addr, exe_value);
        rd_data_b = bypass_read(rd_addr_b, regs_q[rd_addr_b], ent_addr_s, ent_data_s,
                                ent_valid_s, mem_ok_s, mem_reg_addr, mem_value,
                                exe_ok_s, exe_reg_addr, exe_value);
    end

    // Halt FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (do_halt) state_d = DRAIN;
                else         state_d = RUN;
            end
            DRAIN: begin
                if ((count_s == '0) && !do_mem_reg_write && !do_exe_reg_write) state_d = HALTED;
                else                                                          state_d = DRAIN;
            end
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    // Halt FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign halted = (state_q == HALTED);

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based
// reference model of the register file, pending writes and halt behaviour.
module tb_reg_writeback;

    logic        clk;
    logic        rst;
    logic        do_mem_reg_write;
    logic [15:0] mem_value;
    logic [3:0]  mem_reg_addr;
    logic        do_exe_reg_write;
    logic [15:0] exe_value;
    logic [3:0]  exe_reg_addr;
    logic [3:0]  rd_addr_a;
    logic [3:0]  rd_addr_b;
    logic [15:0] rd_data_a;
    logic [15:0] rd_data_b;
    logic        wb_stall;
    logic        do_halt;
    logic        halted;

    reg_writeback dut (
        .clk              (clk),
        .rst              (rst),
        .do_mem_reg_write (do_mem_reg_write),
        .mem_value        (mem_value),
        .mem_reg_addr     (mem_reg_addr),
        .do_exe_reg_write (do_exe_reg_write),
        .exe_value        (exe_value),
        .exe_reg_addr     (exe_reg_addr),
        .rd_addr_a        (rd_addr_a),
        .rd_addr_b        (rd_addr_b),
        .rd_data_a        (rd_data_a),
        .rd_data_b        (rd_data_b),
        .wb_stall         (wb_stall),
        .do_halt          (do_halt),
        .halted           (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  a;
        logic [15:0] d;
    } pend_t;

    logic [15:0] m_regs [16];
    pend_t       m_q [$];
    int          m_mode;      // 0 running, 1 draining, 2 halted
    int          n_checks;
    int          n_errors;
    int          cyc;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_read(input logic [3:0] ra,
                                               input bit mem_ok, input logic [3:0] ma, input logic [15:0] mv,
                                               input bit exe_ok, input logic [3:0] ea, input logic [15:0] ev);
        if (ra == 4'd0) return 16'd0;
        if (exe_ok && ea == ra) return ev;
        if (mem_ok && ma == ra) return mv;
        for (int i = m_q.size() - 1; i >= 0; i--) begin
            if (m_q[i].a == ra) return m_q[i].d;
        end
        return m_regs[ra];
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 16; i++) m_regs[i] = 16'd0;
        m_q.delete();
        m_mode = 0;
    endfunction

    task automatic step(input bit dm, input logic [3:0] ma, input logic [15:0] mv,
                        input bit de, input logic [3:0] ea, input logic [15:0] ev,
                        input bit h, input logic [3:0] ra, input logic [3:0] rb);
        bit    acc, mem_ok, exe_ok, exp_stall;
        int    sz0;
        pend_t p;
        @(negedge clk);
        cyc++;
        do_mem_reg_write = dm; mem_reg_addr = ma; mem_value = mv;
        do_exe_reg_write = de; exe_reg_addr = ea; exe_value = ev;
        do_halt = h; rd_addr_a = ra; rd_addr_b = rb;
        #1;
        sz0       = m_q.size();
        acc       = (m_mode != 2);
        exp_stall = (sz0 == 2) && dm && de;
        mem_ok    = acc && dm && (ma != 4'd0);
        exe_ok    = acc && de && (ea != 4'd0) && !exp_stall;
        check_value("rd_a", 32'(rd_data_a), 32'(model_read(ra, mem_ok, ma, mv, exe_ok, ea, ev)));
        check_value("rd_b", 32'(rd_data_b), 32'(model_read(rb, mem_ok, ma, mv, exe_ok, ea, ev)));
        check_value("stall", 32'(wb_stall), 32'(exp_stall));
        check_value("halted", 32'(halted), 32'(m_mode == 2));
        if (acc) begin
            if (dm) begin
                if (ma != 4'd0) m_regs[ma] = mv;
                if (exe_ok) m_q.push_back('{ea, ev});
            end else if (sz0 > 0) begin
                p = m_q.pop_front();
                m_regs[p.a] = p.d;
                if (exe_ok) m_q.push_back('{ea, ev});
            end else if (exe_ok) begin
                m_regs[ea] = ev;
            end
        end
        if (m_mode == 0 && h) m_mode = 1;
        else if (m_mode == 1 && sz0 == 0 && !dm && !de) m_mode = 2;
    endtask

    task automatic idle(input logic [3:0] ra, input logic [3:0] rb);
        step(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b0, ra, rb);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        do_mem_reg_write = 1'b0; do_exe_reg_write = 1'b0; do_halt = 1'b0;
        mem_reg_addr = 4'd0; exe_reg_addr = 4'd0; mem_value = 16'd0; exe_value = 16'd0;
        rd_addr_a = 4'd1; rd_addr_b = 4'd15;
        rst = 1'b1;
        #1;
        model_clear();
        check_value("rst_rd_a", 32'(rd_data_a), 32'd0);
        check_value("rst_rd_b", 32'(rd_data_b), 32'd0);
        check_value("rst_halted", 32'(halted), 32'd0);
        check_value("rst_stall", 32'(wb_stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_errors = 0; cyc = 0;
        rst = 1'b1;
        do_mem_reg_write = 1'b0; do_exe_reg_write = 1'b0; do_halt = 1'b0;
        mem_value = 16'd0; exe_value = 16'd0; mem_reg_addr = 4'd0; exe_reg_addr = 4'd0;
        rd_addr_a = 4'd0; rd_addr_b = 4'd0;
        model_clear();

        apply_reset();
        idle(4'd1, 4'd15);
        // mem write bypass then array visibility
        step(1'b1, 4'd3, 16'h00AA, 1'b0, 4'd0, 16'd0, 1'b0, 4'd3, 4'd1);
        idle(4'd3, 4'd3);
        // mem + exe in one cycle: exe buffered
        step(1'b1, 4'd4, 16'h0011, 1'b1, 4'd5, 16'h0022, 1'b0, 4'd4, 4'd5);
        idle(4'd5, 4'd4);
        idle(4'd5, 4'd4);
        // fill buffer, stall, re-present
        step(1'b1, 4'd8,  16'h0001, 1'b1, 4'd9,  16'h0002, 1'b0, 4'd9,  4'd8);
        step(1'b1, 4'd10, 16'h0003, 1'b1, 4'd11, 16'h0004, 1'b0, 4'd11, 4'd9);
        step(1'b1, 4'd12, 16'h0005, 1'b1, 4'd13, 16'h0006, 1'b0, 4'd13, 4'd12);
        step(1'b0, 4'd0,  16'h0000, 1'b1, 4'd13, 16'h0006, 1'b0, 4'd13, 4'd11);
        idle(4'd13, 4'd9);
        idle(4'd13, 4'd11);
        idle(4'd13, 4'd11);
        // same destination from both sources: exe is final
        step(1'b1, 4'd6, 16'h0001, 1'b1, 4'd6, 16'h0002, 1'b0, 4'd6, 4'd6);
        idle(4'd6, 4'd0);
        idle(4'd6, 4'd0);
        // writes to r0 are discarded
        step(1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 4'd6);
        step(1'b0, 4'd0, 16'h0000, 1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 4'd6);
        // halt with two pending entries
        step(1'b1, 4'd1, 16'h0101, 1'b1, 4'd2, 16'h0202, 1'b0, 4'd2, 4'd1);
        step(1'b1, 4'd14, 16'h0E0E, 1'b1, 4'd15, 16'h0F0F, 1'b0, 4'd15, 4'd2);
        step(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd2, 4'd15);
        for (int i = 0; i < 3; i++) idle(4'd15, 4'd2);
        step(1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 16'h0009, 1'b0, 4'd7, 4'd15);
        step(1'b1, 4'd7, 16'h0009, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 4'd3);
        idle(4'd7, 4'd1);
        // reset while draining discards everything
        apply_reset();
        step(1'b1, 4'd1, 16'h1111, 1'b1, 4'd2, 16'h2222, 1'b0, 4'd1, 4'd2);
        step(1'b1, 4'd3, 16'h3333, 1'b1, 4'd4, 16'h4444, 1'b1, 4'd4, 4'd2);
        apply_reset();
        idle(4'd2, 4'd4);
        idle(4'd1, 4'd3);

        // random traffic, occasional halts
        for (int r = 0; r < 4; r++) begin
            apply_reset();
            for (int c = 0; c < 250; c++) begin
                step(($urandom_range(0, 99) < 50), 4'($urandom_range(0, 15)), 16'($urandom),
                     ($urandom_range(0, 99) < 60), 4'($urandom_range(0, 15)), 16'($urandom),
                     ($urandom_range(0, 199) == 0),
                     4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
